// File: rtl/vuop_expander.sv
// Expands one vector instruction from the FIFO head into 1/2/4/8 micro-ops (per LMUL).
// Micro-op 0 appears the cycle after the pop; a stalled micro-op holds all outputs until out_ready.
module vuop_expander #(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_flush,
    input  logic          in_valid,
    output logic          in_pop,
    input  logic [1:0]    in_lmul,
    input  logic [4:0]    in_vd,
    input  logic [4:0]    in_vs1,
    input  logic [4:0]    in_vs2,
    input  logic          in_vs1_vec,
    input  logic          in_vs2_vec,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    out_vd,
    output logic [4:0]    out_vs1,
    output logic [4:0]    out_vs2,
    output logic [PW-1:0] out_payload,
    output logic [2:0]    out_uop_idx,
    output logic          out_last
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [1:0]    lmul_q;
    logic [4:0]    vd_q;
    logic [4:0]    vs1_q;
    logic [4:0]    vs2_q;
    logic          vs1_vec_q;
    logic          vs2_vec_q;
    logic [PW-1:0] payload_q;
    logic [2:0]    uop_cnt;
    logic [2:0]    nuop_m1;
    logic          busy;
    logic          fire;

    always_comb begin
        nuop_m1 = 3'd0;
        case (lmul_q)
            2'd0:    nuop_m1 = 3'd0;
            2'd1:    nuop_m1 = 3'd1;
            2'd2:    nuop_m1 = 3'd3;
            default: nuop_m1 = 3'd7;
        endcase
    end

    assign busy        = (state == BUSY);
    assign out_valid   = busy;
    assign out_last    = busy & (uop_cnt == nuop_m1);
    assign fire        = out_valid & out_ready;
    // Pop on the last accepted uop too, so the next instruction follows with no bubble.
    assign in_pop      = ~rst & in_valid & ~valid_flush & (~busy | (fire & out_last));

    // Register-group stepping wraps modulo 32; scalar operands stay at their base index.
    assign out_vd      = vd_q + {2'b00, uop_cnt};
    assign out_vs1     = vs1_vec_q ? vs1_q + {2'b00, uop_cnt} : vs1_q;
    assign out_vs2     = vs2_vec_q ? vs2_q + {2'b00, uop_cnt} : vs2_q;
    assign out_uop_idx = uop_cnt;
    assign out_payload = payload_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lmul_q    <= 2'd0;
            vd_q      <= 5'd0;
            vs1_q     <= 5'd0;
            vs2_q     <= 5'd0;
            vs1_vec_q <= 1'b0;
            vs2_vec_q <= 1'b0;
            payload_q <= '0;
            uop_cnt   <= 3'd0;
        end else if (valid_flush) begin
            state   <= IDLE;
            uop_cnt <= 3'd0;
        end else if (in_pop) begin
            state     <= BUSY;
            lmul_q    <= in_lmul;
            vd_q      <= in_vd;
            vs1_q     <= in_vs1;
            vs2_q     <= in_vs2;
            vs1_vec_q <= in_vs1_vec;
            vs2_vec_q <= in_vs2_vec;
            payload_q <= in_payload;
            uop_cnt   <= 3'd0;
        end else if (fire && !out_last) begin
            uop_cnt <= uop_cnt + 3'd1;
        end else if (fire) begin
            state   <= IDLE;
            uop_cnt <= 3'd0;
        end
    end

endmodule

// File: tb/tb_vuop_expander.sv
// Directed bench for vuop_expander with a small queue standing in for the upstream FIFO.
module tb_vuop_expander;

    typedef struct {
        logic [1:0]  lmul;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic        v1;
        logic        v2;
        logic [31:0] pl;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_flush;
    logic        in_valid;
    logic        in_pop;
    logic [1:0]  in_lmul;
    logic [4:0]  in_vd, in_vs1, in_vs2;
    logic        in_vs1_vec, in_vs2_vec;
    logic [31:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_vd, out_vs1, out_vs2;
    logic [31:0] out_payload;
    logic [2:0]  out_uop_idx;
    logic        out_last;

    ins_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    vuop_expander #(.PW(32)) dut (
        .clk(clk), .rst(rst), .valid_flush(valid_flush),
        .in_valid(in_valid), .in_pop(in_pop), .in_lmul(in_lmul),
        .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
        .in_vs1_vec(in_vs1_vec), .in_vs2_vec(in_vs2_vec), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vd(out_vd), .out_vs1(out_vs1), .out_vs2(out_vs2),
        .out_payload(out_payload), .out_uop_idx(out_uop_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_head();
        if (q.size() > 0) begin
            in_valid   = 1'b1;
            in_lmul    = q[0].lmul;
            in_vd      = q[0].vd;
            in_vs1     = q[0].vs1;
            in_vs2     = q[0].vs2;
            in_vs1_vec = q[0].v1;
            in_vs2_vec = q[0].v2;
            in_payload = q[0].pl;
        end else begin
            in_valid   = 1'b0;
            in_lmul    = 2'd0;
            in_vd      = 5'd0;
            in_vs1     = 5'd0;
            in_vs2     = 5'd0;
            in_vs1_vec = 1'b0;
            in_vs2_vec = 1'b0;
            in_payload = 32'd0;
        end
    endtask

    // One clock: the queue model pops on in_pop and empties on flush, like the real FIFO.
    task automatic step();
        logic p, f;
        #1;
        p = in_pop;
        f = valid_flush;
        @(posedge clk);
        if (f) q.delete();
        else if (p && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
        end
        #1;
        drive_head();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid_flush = 1'b0;
        out_ready = 1'b1;
        q.push_back('{2'd0, 5'd4, 5'd8, 5'd12, 1'b1, 1'b1, 32'hCAFE_0001});
        drive_head();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_idx", out_uop_idx, 0);
        chk("rst_vd", out_vd, 0);
        chk("rst_vs1", out_vs1, 0);
        chk("rst_vs2", out_vs2, 0);
        chk("rst_payload", out_payload, 0);
        chk("rst_pop", in_pop, 0);

        // Single lmul=0 instruction
        rst = 1'b0;
        #1;
        chk("t1_pop_idle", in_pop, 1);
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_vd", out_vd, 4);
        chk("t1_vs1", out_vs1, 8);
        chk("t1_vs2", out_vs2, 12);
        chk("t1_idx", out_uop_idx, 0);
        chk("t1_last", out_last, 1);
        chk("t1_payload", out_payload, 32'hCAFE_0001);
        chk("t1_pop_busy", in_pop, 0);
        step();
        chk("t1_idle", out_valid, 0);
        chk("t1_pops", pops, 1);

        // lmul=3, vs2 scalar, ready toggling 0/1
        q.push_back('{2'd3, 5'd8, 5'd16, 5'd3, 1'b1, 1'b0, 32'h0000_0B0B});
        drive_head();
        out_ready = 1'b0;
        #1;
        chk("t2_pop", in_pop, 1);
        step();
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            #1;
            chk("t2_vd", out_vd, 8 + i);
            chk("t2_vs1", out_vs1, 16 + i);
            chk("t2_vs2", out_vs2, 3);
            chk("t2_idx", out_uop_idx, i);
            chk("t2_last", out_last, (i == 7) ? 1 : 0);
            step();
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_vd", out_vd, 8 + i);
            chk("t2_hold_idx", out_uop_idx, i);
            out_ready = 1'b1;
            #1;
            step();
        end
        chk("t2_idle", out_valid, 0);
        chk("t2_pops", pops, 2);

        // Register wrap-around, vs1 scalar
        q.push_back('{2'd2, 5'd30, 5'd5, 5'd31, 1'b0, 1'b1, 32'h0000_0C0C});
        drive_head();
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t3_vd", out_vd, (30 + i) % 32);
            chk("t3_vs1", out_vs1, 5);
            chk("t3_vs2", out_vs2, (31 + i) % 32);
            chk("t3_last", out_last, (i == 3) ? 1 : 0);
            step();
        end
        chk("t3_idle", out_valid, 0);

        // Back-to-back lmul=1 then lmul=0
        q.push_back('{2'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h0000_0D01});
        q.push_back('{2'd0, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 32'h0000_0D02});
        drive_head();
        #1;
        chk("t4_pop_before", in_pop, 1);
        step();
        chk("t4_a0_valid", out_valid, 1);
        chk("t4_a0_vd", out_vd, 1);
        chk("t4_a0_last", out_last, 0);
        chk("t4_a0_pop", in_pop, 0);
        step();
        chk("t4_a1_valid", out_valid, 1);
        chk("t4_a1_vd", out_vd, 2);
        chk("t4_a1_last", out_last, 1);
        chk("t4_a1_pop", in_pop, 1);
        step();
        chk("t4_b0_valid", out_valid, 1);
        chk("t4_b0_vd", out_vd, 10);
        chk("t4_b0_idx", out_uop_idx, 0);
        chk("t4_b0_last", out_last, 1);
        chk("t4_b0_payload", out_payload, 32'h0000_0D02);
        chk("t4_b0_pop", in_pop, 0);
        step();
        chk("t4_idle", out_valid, 0);

        // Flush on idx 2 of lmul=3 with two instructions queued behind it
        q.push_back('{2'd3, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0000_0E00});
        q.push_back('{2'd0, 5'd20, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0000_0E01});
        q.push_back('{2'd0, 5'd21, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0000_0E02});
        drive_head();
        step();
        step();
        step();
        chk("t5_idx2", out_uop_idx, 2);
        valid_flush = 1'b1;
        #1;
        chk("t5_flush_pop", in_pop, 0);
        pops = 0;
        step();
        valid_flush = 1'b0;
        #1;
        chk("t5_valid_after", out_valid, 0);
        chk("t5_fifo_empty", in_valid, 0);
        step();
        step();
        chk("t5_still_idle", out_valid, 0);
        chk("t5_no_pops", pops, 0);

        // Empty FIFO
        step();
        chk("t6_empty_pop", in_pop, 0);
        chk("t6_empty_valid", out_valid, 0);

        // Asynchronous reset mid-expansion
        q.push_back('{2'd3, 5'd7, 5'd9, 5'd1, 1'b1, 1'b1, 32'h0000_0F0F});
        drive_head();
        step();
        step();
        chk("t7_pre_vd", out_vd, 8);
        chk("t7_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t7_async_valid", out_valid, 0);
        chk("t7_async_last", out_last, 0);
        chk("t7_async_idx", out_uop_idx, 0);
        chk("t7_async_vd", out_vd, 0);
        step();
        rst = 1'b0;
        #1;
        chk("t7_after_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
